// File: rtl/multi_timer.sv
// multi_timer: NUM_CH prescaled down-counters with compare, pulse/PWM outputs and a pending/irq summary.
// Avalon-MM slave with 1-cycle registered read latency; zero wait states, never stalls the bus.
module multi_timer #(
  parameter int NUM_CH       = 4,
  parameter int CNT_W        = 32,
  parameter int PRESCALE_W   = 8,
  parameter int RESET_PERIOD = 49999,
  parameter int ADDR_W       = $clog2((NUM_CH + 1) * 8)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] address,
  input  logic              chipselect,
  input  logic              write_n,
  input  logic [31:0]       writedata,
  output logic [31:0]       readdata,
  output logic              irq,
  output logic [NUM_CH-1:0] ch_out
);

  localparam int                IDX_W = ADDR_W - 3;
  localparam logic [IDX_W-1:0]  G_IDX = IDX_W'(NUM_CH);
  localparam logic [CNT_W-1:0]  RST_P = CNT_W'(RESET_PERIOD);
  localparam logic [CNT_W-1:0]  ONE   = CNT_W'(1);

  logic             wr;
  logic [IDX_W-1:0] blk;
  logic [2:0]       off;

  assign wr  = chipselect && !write_n;
  assign blk = address[ADDR_W-1:3];
  assign off = address[2:0];

  logic [CNT_W-1:0]      cnt     [NUM_CH];
  logic [CNT_W-1:0]      period  [NUM_CH];
  logic [CNT_W-1:0]      compare [NUM_CH];
  logic [CNT_W-1:0]      snap    [NUM_CH];
  logic [NUM_CH-1:0]     run, to, cf, ito, cont, cie, mode, force_reload;
  logic [NUM_CH-1:0]     pend, tmo_evt, dec_evt, wr_ch;
  logic [PRESCALE_W-1:0] prescale, pcnt;
  logic                  tick;
  logic                  wr_prescale;

  assign tick        = (pcnt == '0);
  assign wr_prescale = wr && (blk == G_IDX) && (off == 3'd0);

  always_ff @(posedge clk) begin
    if (reset) begin
      prescale <= '0;
      pcnt     <= '0;
    end else if (wr_prescale) begin
      prescale <= writedata[PRESCALE_W-1:0];
      pcnt     <= writedata[PRESCALE_W-1:0];
    end else if (tick) begin
      pcnt <= prescale;
    end else begin
      pcnt <= pcnt - PRESCALE_W'(1);
    end
  end

  // A pending force_reload masks both counting events for that cycle.
  always_comb begin
    pend    = '0;
    tmo_evt = '0;
    dec_evt = '0;
    wr_ch   = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      pend[c]    = (to[c] && ito[c]) || (cf[c] && cie[c]);
      tmo_evt[c] = run[c] && tick && !force_reload[c] && (cnt[c] == '0);
      dec_evt[c] = run[c] && tick && !force_reload[c] && (cnt[c] != '0);
      wr_ch[c]   = wr && (blk == IDX_W'(c));
    end
  end

  assign irq = |pend;

  // Bus writes are applied first so that later event assignments (flag sets) win.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int c = 0; c < NUM_CH; c++) begin
        cnt[c]     <= RST_P;
        period[c]  <= RST_P;
        compare[c] <= '0;
        snap[c]    <= '0;
      end
      run          <= '0;
      to           <= '0;
      cf           <= '0;
      ito          <= '0;
      cont         <= '0;
      cie          <= '0;
      mode         <= '0;
      force_reload <= '0;
      ch_out       <= '0;
    end else begin
      for (int c = 0; c < NUM_CH; c++) begin
        force_reload[c] <= wr_ch[c] && (off == 3'd2);
        if (wr_ch[c]) begin
          case (off)
            3'd0: begin
              if (writedata[0]) to[c] <= 1'b0;
              if (writedata[2]) cf[c] <= 1'b0;
            end
            3'd1: begin
              ito[c]  <= writedata[0];
              cont[c] <= writedata[1];
              cie[c]  <= writedata[4];
              mode[c] <= writedata[5];
              if (writedata[2])      run[c] <= 1'b1;
              else if (writedata[3]) run[c] <= 1'b0;
            end
            3'd2:    period[c]  <= writedata[CNT_W-1:0];
            3'd3:    compare[c] <= writedata[CNT_W-1:0];
            3'd4:    snap[c]    <= cnt[c];
            default: ;
          endcase
        end
        if (force_reload[c]) begin
          cnt[c] <= period[c];
          run[c] <= 1'b0;
        end else if (tmo_evt[c]) begin
          cnt[c] <= period[c];
          to[c]  <= 1'b1;
          if (!cont[c]) run[c] <= 1'b0;
        end else if (dec_evt[c]) begin
          cnt[c] <= cnt[c] - ONE;
          if ((cnt[c] - ONE) == compare[c]) cf[c] <= 1'b1;
        end
        ch_out[c] <= mode[c] ? (run[c] && (cnt[c] < compare[c])) : tmo_evt[c];
      end
    end
  end

  logic [31:0] rd;

  always_comb begin
    rd = '0;
    if (blk == G_IDX) begin
      case (off)
        3'd0:    rd[PRESCALE_W-1:0] = prescale;
        3'd1:    rd[NUM_CH-1:0]     = pend;
        default: ;
      endcase
    end
    for (int c = 0; c < NUM_CH; c++) begin
      if (blk == IDX_W'(c)) begin
        case (off)
          3'd0:    rd[2:0]       = {cf[c], run[c], to[c]};
          3'd1:    rd[5:0]       = {mode[c], cie[c], 2'b00, cont[c], ito[c]};
          3'd2:    rd[CNT_W-1:0] = period[c];
          3'd3:    rd[CNT_W-1:0] = compare[c];
          3'd4:    rd[CNT_W-1:0] = snap[c];
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) readdata <= '0;
    else       readdata <= rd;
  end

endmodule

// File: tb/tb_multi_timer.sv
// Bench for multi_timer: random register traffic and timing checked against arithmetic expectations.
module tb_multi_timer;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [5:0]  address = '0;
  logic        chipselect = 1'b0;
  logic        write_n = 1'b1;
  logic [31:0] writedata = '0;
  logic [31:0] readdata;
  logic        irq;
  logic [3:0]  ch_out;

  int total = 0;
  int bad = 0;
  localparam int G = 32;
  localparam logic [31:0] RST_P = 32'd49999;

  multi_timer dut (
    .clk(clk), .reset(reset), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .readdata(readdata),
    .irq(irq), .ch_out(ch_out)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  task automatic bus_write(input int a, input logic [31:0] d);
    @(negedge clk);
    chipselect = 1'b1; write_n = 1'b0; address = 6'(a); writedata = d;
    @(posedge clk); #1;
    chipselect = 1'b0; write_n = 1'b1;
  endtask

  task automatic bus_read(input int a, output logic [31:0] d);
    @(negedge clk);
    chipselect = 1'b1; write_n = 1'b1; address = 6'(a);
    @(posedge clk); #1;
    d = readdata; chipselect = 1'b0;
  endtask

  // Returns the number of edges until ch_out[ch] is seen high, or -1 if the budget expires.
  task automatic wait_pulse(input int ch, input int budget, output int cycles);
    cycles = -1;
    for (int i = 1; i <= budget; i++) begin
      @(posedge clk); #1;
      if (ch_out[ch]) begin cycles = i; break; end
    end
  endtask

  task automatic test_reset;
    logic [31:0] r;
    repeat (3) @(posedge clk);
    #1;
    total++; if (irq !== 1'b0) begin bad++; $display("FAIL reset_irq: got %b want 0", irq); end
    total++; if (ch_out !== 4'b0) begin bad++; $display("FAIL reset_ch_out: got %b want 0", ch_out); end
    total++; if (readdata !== 32'd0) begin bad++; $display("FAIL reset_readdata: got %0h want 0", readdata); end
    @(negedge clk) reset = 1'b0;
    for (int c = 0; c < 4; c++) begin
      bus_read(c*8+2, r);
      total++; if (r !== RST_P) begin bad++; $display("FAIL reset_period ch%0d: got %0d want %0d", c, r, RST_P); end
      bus_read(c*8+0, r);
      total++; if (r !== 32'd0) begin bad++; $display("FAIL reset_status ch%0d: got %0h want 0", c, r); end
    end
    bus_read(G+1, r);
    total++; if (r !== 32'd0) begin bad++; $display("FAIL reset_pending: got %0h want 0", r); end
  endtask

  task automatic test_regs;
    logic [31:0] r, v;
    logic [31:0] per_m [4];
    logic [31:0] cmp_m [4];
    for (int c = 0; c < 4; c++) begin
      per_m[c] = $urandom; cmp_m[c] = $urandom;
      bus_write(c*8+2, per_m[c]);
      bus_write(c*8+3, cmp_m[c]);
    end
    for (int c = 0; c < 4; c++) begin
      bus_read(c*8+2, r);
      total++; if (r !== per_m[c]) begin bad++; $display("FAIL regs_period ch%0d: got %0h want %0h", c, r, per_m[c]); end
      bus_read(c*8+3, r);
      total++; if (r !== cmp_m[c]) begin bad++; $display("FAIL regs_compare ch%0d: got %0h want %0h", c, r, cmp_m[c]); end
    end
    v = $urandom & ~32'hC;
    bus_write(9, v);
    bus_read(9, r);
    total++; if (r !== (v & 32'h33)) begin bad++; $display("FAIL regs_control: got %0h want %0h", r, v & 32'h33); end
    bus_write(9, 32'd0);
    v = $urandom;
    bus_write(G, v);
    bus_read(G, r);
    total++; if (r !== (v & 32'hFF)) begin bad++; $display("FAIL regs_prescale: got %0h want %0h", r, v & 32'hFF); end
    bus_write(G, 32'd0);
    bus_write(45, $urandom);
    bus_read(45, r);
    total++; if (r !== 32'd0) begin bad++; $display("FAIL regs_unmapped45: got %0h want 0", r); end
    bus_read(5, r);
    total++; if (r !== 32'd0) begin bad++; $display("FAIL regs_reserved5: got %0h want 0", r); end
    for (int c = 0; c < 4; c++) bus_write(c*8+3, 32'hFFFF_FFFF);
  endtask

  task automatic test_periodic;
    int k, k2;
    logic [31:0] r;
    bus_write(2, 32'd9);
    bus_write(G, 32'd0);
    bus_write(1, 32'd7);
    wait_pulse(0, 20, k);
    total++; if (k < 1 || k > 10) begin bad++; $display("FAIL periodic_first: got %0d cycles want 1..10", k); end
    total++; if (irq !== 1'b1) begin bad++; $display("FAIL periodic_irq: got %b want 1", irq); end
    wait_pulse(0, 20, k2);
    total++; if (k2 !== 10) begin bad++; $display("FAIL periodic_interval: got %0d want 10", k2); end
    bus_write(0, 32'd1);
    total++; if (irq !== 1'b0) begin bad++; $display("FAIL periodic_w1c_irq: got %b want 0", irq); end
    bus_write(1, 32'hF);
    bus_read(0, r);
    total++; if (r[1] !== 1'b1) begin bad++; $display("FAIL start_stop_run: got %b want 1", r[1]); end
    bus_read(1, r);
    total++; if (r !== 32'd3) begin bad++; $display("FAIL start_stop_control: got %0h want 3", r); end
    bus_write(1, 32'd8);
    bus_write(0, 32'd5);
  endtask

  task automatic test_random_periods;
    int per, pre, k, lo, hi;
    for (int it = 0; it < 3; it++) begin
      per = $urandom_range(2, 12);
      pre = $urandom_range(0, 3);
      lo = per * (pre + 1) + 1;
      hi = (per + 1) * (pre + 1);
      bus_write(2, 32'(per));
      bus_write(G, 32'(pre));
      bus_write(1, 32'd7);
      wait_pulse(0, 200, k);
      total++; if (k < lo || k > hi) begin bad++; $display("FAIL rand_first P=%0d p=%0d: got %0d want %0d..%0d", per, pre, k, lo, hi); end
      wait_pulse(0, 200, k);
      total++; if (k !== hi) begin bad++; $display("FAIL rand_interval P=%0d p=%0d: got %0d want %0d", per, pre, k, hi); end
      bus_write(1, 32'd8);
      bus_write(0, 32'd5);
    end
  endtask

  task automatic test_oneshot;
    int k;
    logic [31:0] r;
    bus_write(10, 32'd3);
    bus_write(G, 32'd2);
    bus_write(9, 32'd5);
    wait_pulse(1, 12, k);
    total++; if (k < 10 || k > 12) begin bad++; $display("FAIL oneshot_first: got %0d want 10..12", k); end
    total++; if (irq !== 1'b1) begin bad++; $display("FAIL oneshot_irq: got %b want 1", irq); end
    wait_pulse(1, 40, k);
    total++; if (k !== -1) begin bad++; $display("FAIL oneshot_extra_pulse: got %0d want -1", k); end
    bus_read(8, r);
    total++; if (r !== 32'd1) begin bad++; $display("FAIL oneshot_status: got %0h want 1", r); end
    bus_write(12, 32'd0);
    bus_read(12, r);
    total++; if (r !== 32'd3) begin bad++; $display("FAIL oneshot_hold: got %0d want 3", r); end
    bus_write(8, 32'd5);
  endtask

  task automatic test_pwm;
    int highs;
    logic [31:0] r;
    bus_write(G, 32'd0);
    bus_write(18, 32'd9);
    bus_write(19, 32'd4);
    bus_write(17, 32'd54);
    repeat (12) @(posedge clk);
    highs = 0;
    for (int i = 0; i < 30; i++) begin
      @(posedge clk); #1;
      if (ch_out[2]) highs++;
    end
    total++; if (highs !== 12) begin bad++; $display("FAIL pwm_duty: got %0d high of 30 want 12", highs); end
    bus_read(16, r);
    total++; if (r !== 32'd7) begin bad++; $display("FAIL pwm_status: got %0h want 7", r); end
    bus_read(G+1, r);
    total++; if (r !== 32'd4) begin bad++; $display("FAIL pwm_pending: got %0h want 4", r); end
    total++; if (irq !== 1'b1) begin bad++; $display("FAIL pwm_irq: got %b want 1", irq); end
    bus_write(17, 32'd8);
    bus_write(16, 32'd5);
    total++; if (irq !== 1'b0) begin bad++; $display("FAIL pwm_clear_irq: got %b want 0", irq); end
  endtask

  task automatic test_period_write;
    logic [31:0] r, newp;
    bus_write(26, 32'd1000);
    @(posedge clk);
    bus_write(25, 32'd6);
    repeat (5) @(posedge clk);
    newp = 32'($urandom_range(50, 500));
    bus_write(26, newp);
    @(posedge clk);
    bus_write(28, 32'd0);
    bus_read(28, r);
    total++; if (r !== newp) begin bad++; $display("FAIL pwrite_snap: got %0d want %0d", r, newp); end
    bus_read(24, r);
    total++; if (r[1] !== 1'b0) begin bad++; $display("FAIL pwrite_run: got %b want 0", r[1]); end
    repeat (5) @(posedge clk);
    bus_write(28, 32'd0);
    bus_read(28, r);
    total++; if (r !== newp) begin bad++; $display("FAIL pwrite_hold: got %0d want %0d", r, newp); end
  endtask

  task automatic test_collision;
    bus_write(0, 32'd5);
    bus_write(2, 32'd9);
    bus_write(G, 32'd0);
    bus_write(1, 32'd7);
    repeat (14) @(posedge clk);
    bus_write(0, 32'd1);
    total++; if (irq !== 1'b0) begin bad++; $display("FAIL collide_pre_clear: got %b want 0", irq); end
    repeat (4) @(posedge clk);
    bus_write(0, 32'd1);
    total++; if (ch_out[0] !== 1'b1) begin bad++; $display("FAIL collide_pulse: got %b want 1", ch_out[0]); end
    total++; if (irq !== 1'b1) begin bad++; $display("FAIL collide_set_wins: got %b want 1", irq); end
    bus_write(0, 32'd1);
    total++; if (irq !== 1'b0) begin bad++; $display("FAIL collide_post_clear: got %b want 0", irq); end
  endtask

  task automatic test_reset_midcount;
    logic [31:0] r;
    repeat (7) @(posedge clk);
    @(negedge clk) reset = 1'b1;
    @(posedge clk); #1;
    total++; if (irq !== 1'b0) begin bad++; $display("FAIL midreset_irq: got %b want 0", irq); end
    total++; if (ch_out !== 4'b0) begin bad++; $display("FAIL midreset_ch_out: got %b want 0", ch_out); end
    total++; if (readdata !== 32'd0) begin bad++; $display("FAIL midreset_readdata: got %0h want 0", readdata); end
    @(negedge clk) reset = 1'b0;
    bus_read(0, r);
    total++; if (r !== 32'd0) begin bad++; $display("FAIL midreset_status: got %0h want 0", r); end
    bus_read(1, r);
    total++; if (r !== 32'd0) begin bad++; $display("FAIL midreset_control: got %0h want 0", r); end
    bus_read(2, r);
    total++; if (r !== RST_P) begin bad++; $display("FAIL midreset_period: got %0d want %0d", r, RST_P); end
    bus_read(G, r);
    total++; if (r !== 32'd0) begin bad++; $display("FAIL midreset_prescale: got %0h want 0", r); end
    bus_write(4, 32'd0);
    bus_read(4, r);
    total++; if (r !== RST_P) begin bad++; $display("FAIL midreset_counter: got %0d want %0d", r, RST_P); end
  endtask

  initial begin
    test_reset();
    test_regs();
    test_periodic();
    test_random_periods();
    test_oneshot();
    test_pwm();
    test_period_write();
    test_collision();
    test_reset_midcount();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/multi_timer.md
# multi_timer

Parametrised multi-channel interval timer on the Avalon-MM slave bus. It is the successor to the single-channel 16-bit-bus interval timer. Features:
- NUM_CH independent down-counters of CNT_W bits sharing one programmable prescaler.
- Per-channel compare register with a compare interrupt.
- Per-channel output in pulse or PWM mode.
- Per-channel snapshot, and a global interrupt-pending register.

## Interface
- NUM_CH, 4, channel count (1..8)
- CNT_W, 32, counter/period/compare width (16..32)
- PRESCALE_W, 8, prescaler width
- RESET_PERIOD, 49999, reset value of every period register and counter
- ADDR_W, clog2((NUM_CH+1)*8), word address width
- clk  input  1  system clock; all logic on rising edge
- reset  input  1  synchronous, active-high reset
- address  input  ADDR_W  word address
- chipselect  input  1  slave select
- write_n  input  1  active-low write
- writedata  input  32  write data; bits above field width ignored
- readdata  output  32  registered read data, zero-extended
- irq  output  1  OR of all enabled channel flags
- ch_out  output  NUM_CH  per-channel pulse/PWM output

## Operation
- Write strobe is `chipselect && !write_n`.
- Channel c owns word addresses c*8+0..7. Global block is at G = NUM_CH*8. Unmapped addresses read 0 and ignore writes.
- Per-channel registers:
  - +0 STATUS: bit0 TO, bit1 RUN (RO), bit2 CF. Write-1-to-clear on bits 0 and 2.
  - +1 CONTROL: bit0 ITO, bit1 CONT, bit4 CIE, bit5 MODE (0 = pulse, 1 = PWM) are stored. bit2 START and bit3 STOP are strobes, not stored, and read 0.
  - +2 PERIOD.
  - +3 COMPARE.
  - +4 SNAP: any write copies the counter. Read returns the snapshot.
  - +5..+7 read 0.
- Global registers:
  - G+0 PRESCALE (PRESCALE_W bits).
  - G+1 PENDING (RO): bit c = (TO&ITO | CF&CIE) of channel c.
- Prescaler counts PRESCALE down to 0, then reloads. `tick` is high in the cycle it is 0. PRESCALE=0 gives a tick every cycle.
  - A write to PRESCALE reloads the prescaler counter to the new value.
- Each channel updates on ticks only, in this priority order:
  1. force_reload (set for one cycle after any PERIOD write; acts regardless of tick): counter <= PERIOD, RUN <= 0.
  2. RUN && tick && counter==0: counter <= PERIOD, TO <= 1, pulse event. If !CONT, RUN <= 0.
  3. RUN && tick: counter <= counter-1. If counter-1 == COMPARE, CF <= 1.
- START sets RUN; STOP clears RUN. START and STOP in the same write: START wins. STOP does not reload the counter.
- Flag set and W1C clear in the same cycle: set wins.
- ch_out:
  - MODE=0: one-cycle high on a timeout event.
  - MODE=1: high while RUN && counter < COMPARE (registered).
- irq = |PENDING, combinational from flag and control registers.
- Arithmetic is unsigned CNT_W. The counter never underflows because 0 reloads.
- Reset values: counters and PERIOD = RESET_PERIOD[CNT_W-1:0]. COMPARE, SNAP, CONTROL, STATUS, PRESCALE, prescaler counter = 0. readdata, irq, ch_out = 0.

## Timing
- Write at edge N: the register holds the new value after edge N. RUN changes at edge N for START/STOP.
- PERIOD write at edge N: force_reload is high in cycle N+1, and the counter holds the new PERIOD after edge N+1.
- Read: address sampled at edge N, readdata valid after edge N (1-cycle latency). Reads have no side effects.
- With PRESCALE=p and PERIOD=P, timeouts occur every (P+1)*(p+1) cycles.
- First timeout after START: between P*(p+1)+1 and (P+1)*(p+1) cycles, depending on prescaler phase.
- Pulse-mode ch_out and TO rise on the same edge. irq follows TO/CF with 0 extra cycles.
- Reset asserted mid-count: every state returns to its reset value at the next edge. No count occurs in that cycle.

## Test plan
- Reset: all channels read PERIOD=RESET_PERIOD, STATUS=0, readdata=0, irq=0, ch_out=0.
- Ch0: PERIOD=9, PRESCALE=0, CONTROL=ITO|CONT|START -> TO and irq rise at most 10 cycles after START, then every 10 cycles. W1C to STATUS bit0 drops irq; START+STOP in one write leaves RUN=1.
- Ch1: PERIOD=3, PRESCALE=2, CONT=0, START -> exactly one timeout within 12 cycles. RUN clears on the same edge as TO; the counter then holds 3.
- Ch2: PERIOD=9, COMPARE=4, MODE=1, CIE, CONT -> ch_out[2] high 4 of every 10 ticks. CF sets when the counter reaches 4, and PENDING[2]=1.
- PERIOD write while running -> the counter equals the new PERIOD after 2 edges and RUN=0. SNAP write then SNAP read returns that value.
- Simultaneous TO event and W1C clear in the same cycle -> TO stays 1. Reset asserted mid-count -> all state equals reset values next cycle.
